pe_multi_filter: RTL and testbench
==================================

PE_MULTI_FILTER -- requirements
Module: pe_multi_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel and filter operand width (unsigned).
REQ-002 SHALL have parameter ACC_W, default 24, per-filter accumulator width.
REQ-003 SHALL have parameter OUT_W, default 8, saturated result width per filter.
REQ-004 SHALL have parameter NUM_FILT, default 4, filter channels, i.e. accumulators and result-buffer slots.
REQ-005 SHALL have parameter MEM_DEPTH, default 128, output-memory words; each word is NUM_FILT*OUT_W bits.
REQ-006 SHALL have ports: clk input 1, the single clock; rst input 1, synchronous active-low reset.
REQ-007 SHALL have ports: in_valid input 1, operand strobe; img_pixel input DATA_W; filter_value input DATA_W; filt_sel input clog2(NUM_FILT), target channel.
REQ-008 SHALL have ports: acc_last input 1, marks final product of a window; acc_clr input 1, clears all accumulators; res_clr input 1, clears the result buffer.
REQ-009 SHALL have ports: wr_en input 1, store result buffer to memory; drain_start input 1; out_ready input 1.
REQ-010 SHALL have ports: out_valid output 1; out_data output NUM_FILT*OUT_W; drain_done output 1; mem_full output 1; wr_count output clog2(MEM_DEPTH+1); sat_flag output 1; ovf_flag output 1.

Function
REQ-011 SHALL, on in_valid with acc_clr low, add img_pixel*filter_value (zero-extended, wraps modulo 2^ACC_W) to acc[filt_sel] at the clock edge.
REQ-012 SHALL, on in_valid with acc_last high, write sat(acc[filt_sel]+product) into res_buf[filt_sel] and clear acc[filt_sel] in the same edge; result visible the next cycle.
REQ-013 SHALL saturate: sum > 2^OUT_W-1 stores 2^OUT_W-1 and sets sticky sat_flag; otherwise stores the low OUT_W bits.
REQ-014 SHALL give acc_clr priority over in_valid: all accumulators cleared, operands of that cycle dropped.
REQ-015 SHALL clear all res_buf slots on res_clr; a concurrent acc_last update to res_buf SHALL win for its slot.
REQ-016 SHALL pack res_buf with slot 0 at bits [OUT_W-1:0], slot k at [(k+1)*OUT_W-1:k*OUT_W].
REQ-017 SHALL, on wr_en in state IDLE with mem_full low, write packed res_buf (pre-edge value) to mem[wr_count] and increment wr_count.
REQ-018 SHALL assert mem_full combinationally when wr_count==MEM_DEPTH; wr_en while full is dropped and sets sticky ovf_flag.
REQ-019 SHALL implement FSM states IDLE, DRAIN, DONE; reset state IDLE.
REQ-020 SHALL, in IDLE on drain_start with wr_count>0, go to DRAIN with read pointer 0; with wr_count==0, go to DONE.
REQ-021 SHALL, in DRAIN, drive out_valid=1 and out_data=mem[rd_ptr]; on out_valid&out_ready increment rd_ptr; the transfer with rd_ptr==wr_count-1 moves to DONE.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, in DONE, pulse drain_done for exactly one cycle, clear wr_count, sat_flag and ovf_flag, and return to IDLE.
REQ-024 SHALL ignore wr_en and drain_start outside IDLE (ovf_flag unaffected); MAC/accumulation SHALL continue in all states.
REQ-025 SHALL drive out_valid=0 and out_data=0 outside DRAIN.

Reset
REQ-026 SHALL, on rst low at a clock edge, clear all accumulators, res_buf, wr_count, rd_ptr, sat_flag, ovf_flag, and enter IDLE; out_valid, drain_done = 0.
REQ-027 SHALL treat reset mid-DRAIN as abort: no further transfers, memory contents not cleared but unreachable (wr_count=0).

Verification
REQ-028 SHALL cover accumulation: 3 products 2*3, 4*5, 1*1 to filt 1, last on third -> res_buf slot1=27, acc[1]=0, sat_flag=0.
REQ-029 SHALL cover saturation: 255*255 with acc_last, OUT_W=8 -> slot=255, sat_flag=1.
REQ-030 SHALL cover store/drain: slots {4,3,2,1}, wr_en twice, drain_start, out_ready=1 -> two beats of 0x01020304, then drain_done one cycle, wr_count=0.
REQ-031 SHALL cover backpressure: out_ready low 3 cycles mid-drain -> out_data constant, no beat lost or duplicated.
REQ-032 SHALL cover overflow: MEM_DEPTH+1 wr_en -> mem_full=1, wr_count=MEM_DEPTH, ovf_flag=1; empty drain -> drain_done the cycle after IDLE->DONE, no out_valid.
REQ-033 SHALL cover reset mid-DRAIN and acc_clr+in_valid same cycle -> IDLE, out_valid=0; accumulator 0.

Source files
------------

// File: rtl/pe_multi_filter.sv
// pe_multi_filter
//   Multi-channel multiply-accumulate processing element. Each of NUM_FILT
//   channels accumulates img_pixel*filter_value products. When a window
//   closes (acc_last), the channel's saturated result is written into a
//   result buffer. The packed result buffer can be stored into an output
//   memory (wr_en). The memory is later drained over a valid/ready stream
//   (drain_start, out_valid/out_ready), and the drain ends with a one-cycle
//   drain_done pulse.
//
// Ports
//   clk          single clock
//   rst          synchronous reset, active low
//   in_valid     operand strobe (img_pixel, filter_value, filt_sel)
//   acc_last     final product of a window for channel filt_sel
//   acc_clr      clears every accumulator; operands of that cycle are dropped
//   res_clr      clears the result buffer
//   wr_en        store packed result buffer into memory (IDLE only)
//   drain_start  begin streaming stored words (IDLE only)
//   out_ready    downstream ready
//   out_valid    stream valid (DRAIN only)
//   out_data     stream data, NUM_FILT*OUT_W bits, slot 0 in the low bits
//   drain_done   one-cycle pulse at the end of a drain
//   mem_full     memory holds MEM_DEPTH words
//   wr_count     number of stored words
//   sat_flag     sticky: some result saturated since the last drain
//   ovf_flag     sticky: some store was dropped because memory was full
module pe_multi_filter #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 8,
  parameter int NUM_FILT  = 4,
  parameter int MEM_DEPTH = 128,
  localparam int SEL_W    = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1,
  localparam int CNT_W    = $clog2(MEM_DEPTH + 1),
  localparam int WORD_W   = NUM_FILT * OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] img_pixel,
  input  logic [DATA_W-1:0] filter_value,
  input  logic [SEL_W-1:0]  filt_sel,
  input  logic              acc_last,
  input  logic              acc_clr,
  input  logic              res_clr,
  input  logic              wr_en,
  input  logic              drain_start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              drain_done,
  output logic              mem_full,
  output logic [CNT_W-1:0]  wr_count,
  output logic              sat_flag,
  output logic              ovf_flag
);

  localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    wr_count_reg;
  logic [CNT_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic                sat_flag_reg, ovf_flag_reg;
  logic [WORD_W-1:0]   res_packed;
  logic [WORD_W-1:0]   rd_data_reg;
  logic [NUM_FILT-1:0] sat_hit;
  logic [PROD_W-1:0]   product;
  logic [ACC_W-1:0]    product_ext;
  logic                mac_en;
  logic                wr_accept, wr_drop;

  logic [WORD_W-1:0]   mem [MEM_DEPTH];

  // acc_clr wins over in_valid: the whole cycle's operands are discarded.
  assign mac_en      = in_valid & ~acc_clr;
  assign product     = PROD_W'(img_pixel) * PROD_W'(filter_value);
  assign product_ext = ACC_W'(product);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FILT; gi++) begin : g_filt
      logic [ACC_W-1:0] acc_reg;
      logic [OUT_W-1:0] res_buf_reg;
      logic [ACC_W-1:0] sum;
      logic             hit;
      logic             over;

      assign hit  = mac_en && (filt_sel == SEL_W'(gi));
      assign sum  = acc_reg + product_ext;
      assign over = |sum[ACC_W-1:OUT_W];
      assign sat_hit[gi] = hit & acc_last & over;
      assign res_packed[gi*OUT_W +: OUT_W] = res_buf_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          acc_reg     <= '0;
          res_buf_reg <= '0;
        end else begin
          if (acc_clr)
            acc_reg <= '0;
          else if (hit)
            acc_reg <= acc_last ? '0 : sum;

          // A window closing on this slot beats a simultaneous res_clr.
          if (hit && acc_last)
            res_buf_reg <= over ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
          else if (res_clr)
            res_buf_reg <= '0;
        end
      end
    end
  endgenerate

  assign mem_full  = (wr_count_reg == CNT_W'(MEM_DEPTH));
  assign wr_accept = (state_reg == IDLE) & wr_en & ~mem_full;
  assign wr_drop   = (state_reg == IDLE) & wr_en & mem_full;

  // Registered read addressed by the next read pointer, so the word for the
  // current rd_ptr is already in rd_data_reg when DRAIN presents it. Under
  // backpressure the same address is re-read, keeping out_data stable.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_count_reg[ADDR_W-1:0]] <= res_packed;
    rd_data_reg <= mem[rd_ptr_next[ADDR_W-1:0]];
  end

  always_comb begin
    state_next  = state_reg;
    rd_ptr_next = rd_ptr_reg;
    out_valid   = 1'b0;
    drain_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (drain_start) begin
          if (wr_count_reg != '0) begin
            state_next  = DRAIN;
            rd_ptr_next = '0;
          end else begin
            state_next  = DONE;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rd_ptr_next = rd_ptr_reg + CNT_W'(1);
          if (rd_ptr_next == wr_count_reg)
            state_next = DONE;
        end
      end
      DONE: begin
        drain_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      rd_ptr_reg   <= '0;
      wr_count_reg <= '0;
      sat_flag_reg <= 1'b0;
      ovf_flag_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rd_ptr_reg <= rd_ptr_next;

      if (state_reg == DONE)
        wr_count_reg <= '0;
      else if (wr_accept)
        wr_count_reg <= wr_count_reg + CNT_W'(1);

      // A saturation landing in the DONE cycle is kept rather than lost.
      if (|sat_hit)
        sat_flag_reg <= 1'b1;
      else if (state_reg == DONE)
        sat_flag_reg <= 1'b0;

      if (state_reg == DONE)
        ovf_flag_reg <= 1'b0;
      else if (wr_drop)
        ovf_flag_reg <= 1'b1;
    end
  end

  assign out_data = (state_reg == DRAIN) ? rd_data_reg : '0;
  assign wr_count = wr_count_reg;
  assign sat_flag = sat_flag_reg;
  assign ovf_flag = ovf_flag_reg;

endmodule

// File: tb/tb_pe_multi_filter.sv
module tb_pe_multi_filter;
  localparam int MEM_DEPTH = 128;
  localparam int M_IDLE = 0, M_DRAIN = 1, M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  img_pixel, filter_value;
  logic [1:0]  filt_sel;
  logic        acc_last, acc_clr, res_clr, wr_en, drain_start, out_ready;
  logic        out_valid, drain_done, mem_full, sat_flag, ovf_flag;
  logic [31:0] out_data;
  logic [7:0]  wr_count;

  pe_multi_filter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .img_pixel(img_pixel),
    .filter_value(filter_value), .filt_sel(filt_sel), .acc_last(acc_last),
    .acc_clr(acc_clr), .res_clr(res_clr), .wr_en(wr_en),
    .drain_start(drain_start), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .drain_done(drain_done), .mem_full(mem_full),
    .wr_count(wr_count), .sat_flag(sat_flag), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural reference model
  int unsigned acc_m [4];
  int unsigned res_m [4];
  logic [31:0] mem_m [MEM_DEPTH];
  int          wc_m, rp_m, mode_m;
  bit          sat_m, ovf_m;

  // Drain observation results
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  int done_cnt, done_at, stall_bad, valid_cnt;

  task automatic clear_inputs();
    in_valid = 0; img_pixel = 0; filter_value = 0; filt_sel = 0;
    acc_last = 0; acc_clr = 0; res_clr = 0; wr_en = 0;
    drain_start = 0; out_ready = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge.
  task automatic tick();
    int unsigned packed_pre, s;
    @(posedge clk);
    packed_pre = res_m[0] | (res_m[1] << 8) | (res_m[2] << 16) | (res_m[3] << 24);
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin acc_m[k] = 0; res_m[k] = 0; end
      wc_m = 0; rp_m = 0; sat_m = 0; ovf_m = 0; mode_m = M_IDLE;
    end else begin
      case (mode_m)
        M_IDLE: begin
          if (drain_start) begin
            if (wc_m > 0) begin mode_m = M_DRAIN; rp_m = 0; end
            else mode_m = M_DONE;
          end
          if (wr_en) begin
            if (wc_m == MEM_DEPTH) ovf_m = 1;
            else begin mem_m[wc_m] = packed_pre; wc_m++; end
          end
        end
        M_DRAIN: if (out_ready) begin
          rp_m++;
          if (rp_m == wc_m) mode_m = M_DONE;
        end
        default: begin wc_m = 0; sat_m = 0; ovf_m = 0; mode_m = M_IDLE; end
      endcase
      if (acc_clr) for (int k = 0; k < 4; k++) acc_m[k] = 0;
      if (res_clr) for (int k = 0; k < 4; k++) res_m[k] = 0;
      if (in_valid && !acc_clr) begin
        s = (acc_m[filt_sel] + 32'(img_pixel) * 32'(filter_value)) & 32'h00FF_FFFF;
        if (acc_last) begin
          acc_m[filt_sel] = 0;
          if (s > 255) begin res_m[filt_sel] = 255; sat_m = 1; end
          else res_m[filt_sel] = s;
        end else acc_m[filt_sel] = s;
      end
    end
    #1;
  endtask

  task automatic mac(input int sel, input int px, input int fv, input bit last);
    in_valid = 1; filt_sel = 2'(sel); img_pixel = 8'(px); filter_value = 8'(fv);
    acc_last = last;
    tick();
    in_valid = 0; acc_last = 0;
  endtask

  task automatic pulse_wr();
    wr_en = 1; tick(); wr_en = 0;
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int i = 0; i < wc_m; i++) exp_q.push_back(mem_m[i]);
  endtask

  // ready_mode: 0 always ready, 1 random, 2 three stall cycles after first beat.
  // wr_during: hold wr_en high while out_valid (must be ignored).
  task automatic do_drain(input int ready_mode, input bit wr_during);
    logic [31:0] held;
    bit holding;
    int stall_cnt;
    got_q.delete();
    done_cnt = 0; done_at = -1; stall_bad = 0; valid_cnt = 0;
    holding = 0; stall_cnt = 3; held = '0;
    drain_start = 1; tick(); drain_start = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (drain_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (holding && out_valid && out_data !== held) stall_bad++;
      case (ready_mode)
        0: out_ready = 1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (got_q.size() >= 1 && stall_cnt > 0) begin out_ready = 0; stall_cnt--; end
          else out_ready = 1;
        end
      endcase
      wr_en = wr_during & out_valid;
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        $display("drain beat %0d data=0x%08h", got_q.size() - 1, out_data);
        holding = 0;
      end else if (out_valid) begin
        holding = 1; held = out_data;
      end else holding = 0;
      if (done_at >= 0 && cyc > done_at) break;
      tick();
    end
    wr_en = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done got=%b exp=0", drain_done); end
    total++; if (wr_count !== 8'd0) begin bad++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    total++; if (sat_flag !== 1'b0 || ovf_flag !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", sat_flag, ovf_flag); end
    total++; if (mem_full !== 1'b0) begin bad++; $display("FAIL reset_mem_full got=%b exp=0", mem_full); end
    total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    rst = 1; tick();
  endtask

  task automatic test_accumulate();
    mac(1, 2, 3, 0); mac(1, 4, 5, 0); mac(1, 1, 1, 1);
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL acc_sat got=%b exp=0", sat_flag); end
    pulse_wr();
    total++; if (wr_count !== 8'd1) begin bad++; $display("FAIL acc_wr_count got=%0d exp=1", wr_count); end
    mac(1, 1, 1, 1);  // accumulator must have restarted from 0
    pulse_wr();
    do_drain(0, 0);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL acc_beats got=%0d exp=2", got_q.size()); end
    total++; if (got_q[0] !== 32'h0000_1B00) begin bad++; $display("FAIL acc_word0 got=%h exp=00001b00", got_q[0]); end
    total++; if (got_q[1] !== 32'h0000_0100) begin bad++; $display("FAIL acc_word1 got=%h exp=00000100", got_q[1]); end
    total++; if (done_cnt != 1 || done_at != 2) begin bad++; $display("FAIL acc_done got=%0d@%0d exp=1@2", done_cnt, done_at); end
  endtask

  task automatic test_saturate();
    mac(2, 255, 255, 1);
    total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", sat_flag); end
    pulse_wr();
    build_exp();
    do_drain(0, 0);
    total++; if (got_q[0] !== 32'h00FF_0100) begin bad++; $display("FAIL sat_word got=%h exp=00ff0100", got_q[0]); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_cleared got=%b exp=0", sat_flag); end
  endtask

  task automatic test_store_drain();
    res_clr = 1; tick(); res_clr = 0;
    mac(0, 4, 1, 1); mac(1, 3, 1, 1); mac(2, 2, 1, 1); mac(3, 1, 1, 1);
    pulse_wr(); pulse_wr();
    do_drain(0, 0);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL sd_beats got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      total++; if (got_q[i] !== 32'h0102_0304) begin bad++; $display("FAIL sd_word%0d got=%h exp=01020304", i, got_q[i]); end
    end
    total++; if (done_cnt != 1 || done_at != 2) begin bad++; $display("FAIL sd_done got=%0d@%0d exp=1@2", done_cnt, done_at); end
    total++; if (wr_count !== 8'd0) begin bad++; $display("FAIL sd_wr_count got=%0d exp=0", wr_count); end
  endtask

  task automatic test_res_clr();
    res_clr = 1; mac(3, 7, 1, 1); res_clr = 0;
    pulse_wr();
    do_drain(0, 0);
    total++; if (got_q[0] !== 32'h0700_0000) begin bad++; $display("FAIL resclr_word got=%h exp=07000000", got_q[0]); end
  endtask

  task automatic test_backpressure();
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 4; j++)
        mac($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), 1);
      pulse_wr();
    end
    build_exp();
    do_drain(2, 1);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL bp_beats got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stall_bad); end
    total++; if (valid_cnt != 7) begin bad++; $display("FAIL bp_valid_cycles got=%0d exp=7", valid_cnt); end
    total++; if (wr_count !== 8'd0 || ovf_flag !== 1'b0) begin bad++; $display("FAIL bp_ignore_wr got=%0d/%b exp=0/0", wr_count, ovf_flag); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= MEM_DEPTH; i++) begin
      mac(i % 4, i, 1, 1);
      pulse_wr();
    end
    total++; if (mem_full !== 1'b1) begin bad++; $display("FAIL ovf_mem_full got=%b exp=1", mem_full); end
    total++; if (wr_count !== 8'(MEM_DEPTH)) begin bad++; $display("FAIL ovf_wr_count got=%0d exp=%0d", wr_count, MEM_DEPTH); end
    total++; if (ovf_flag !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ovf_flag); end
    build_exp();
    do_drain(1, 0);
    total++; if (got_q.size() != MEM_DEPTH) begin bad++; $display("FAIL ovf_beats got=%0d exp=%0d", got_q.size(), MEM_DEPTH); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (ovf_flag !== 1'b0 || mem_full !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b/%b exp=0/0", ovf_flag, mem_full); end
    do_drain(0, 0);
    total++; if (done_cnt != 1 || done_at != 0) begin bad++; $display("FAIL empty_done got=%0d@%0d exp=1@0", done_cnt, done_at); end
    total++; if (valid_cnt != 0) begin bad++; $display("FAIL empty_valid got=%0d exp=0", valid_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    int stray;
    pulse_wr(); pulse_wr(); pulse_wr();
    drain_start = 1; tick(); drain_start = 0;
    out_ready = 1; tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmd_draining got=%b exp=1", out_valid); end
    rst = 0; tick();
    total++; if (out_valid !== 1'b0 || out_data !== 32'd0) begin bad++; $display("FAIL rmd_abort got=%b/%h exp=0/0", out_valid, out_data); end
    total++; if (wr_count !== 8'd0) begin bad++; $display("FAIL rmd_wr_count got=%0d exp=0", wr_count); end
    rst = 1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (out_valid || drain_done) stray++; end
    out_ready = 0;
    total++; if (stray != 0) begin bad++; $display("FAIL rmd_stray got=%0d exp=0", stray); end
    // acc_clr with in_valid in the same cycle drops the operands
    mac(0, 10, 10, 0);
    acc_clr = 1; mac(0, 200, 200, 1); acc_clr = 0;
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL accclr_sat got=%b exp=0", sat_flag); end
    mac(0, 1, 1, 1);
    pulse_wr();
    do_drain(0, 0);
    total++; if (got_q[0] !== 32'h0000_0001) begin bad++; $display("FAIL accclr_word got=%h exp=00000001", got_q[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      filt_sel     = 2'($urandom_range(0, 3));
      img_pixel    = 8'($urandom);
      filter_value = 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 3));
      acc_last     = ($urandom_range(0, 3) == 0);
      acc_clr      = ($urandom_range(0, 29) == 0);
      res_clr      = ($urandom_range(0, 19) == 0);
      wr_en        = ($urandom_range(0, 9) == 0);
      tick();
    end
    clear_inputs();
    total++; if (sat_flag !== sat_m) begin bad++; $display("FAIL rnd_sat got=%b exp=%b", sat_flag, sat_m); end
    total++; if (wr_count !== 8'(wc_m)) begin bad++; $display("FAIL rnd_wr_count got=%0d exp=%0d", wr_count, wc_m); end
    build_exp();
    do_drain(1, 1);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL rnd_stable got=%0d exp=0", stall_bad); end
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    test_reset();
    test_accumulate();
    test_saturate();
    test_store_drain();
    test_res_clr();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
